lif_core: RTL and testbench

Leaky integrate-and-fire neuron datapath that consumes the tau, weight and threshold bytes produced by the serial configuration loader.
- Advances one time step per step_en pulse.
- Each step applies leak, adds weight when an input spike is present, and fires when the membrane potential reaches threshold.
- Fire is followed by a programmable refractory period.
- Held cleared while the loader is shifting in new configuration.

---
 rtl/lif_pkg.sv | 24 ++
 rtl/lif_leak_timer.sv | 24 ++
 rtl/lif_core.sv | 123 ++++++++++++
 tb/tb_lif_core.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and defaults for the leaky integrate-and-fire neuron.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INTEG  = 2'd1,
    FIRE   = 2'd2,
    REFRAC = 2'd3
  } lif_state_e;

  localparam int VW_DEF            = 10;
  localparam int LEAK_SHIFT_DEF    = 3;
  localparam int REFRACT_STEPS_DEF = 4;

  // Unsigned a+b clamped to max; the sum is kept one bit wider so it cannot wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_leak_timer.sv
// Leak interval counter: leak_now is high on the step where the count equals tau.
// The count wraps 255 -> 0, so a tau lowered below the count waits for the wrap.
module lif_leak_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       freeze,
  input  logic [7:0] tau,
  output logic       leak_now
);

  logic [7:0] leak_cnt;

  assign leak_now = (leak_cnt == tau);

  // Count steps; restart after each leak, hold whenever the core is not stepping.
  always_ff @(posedge clk) begin
    if (!rst || clear)
      leak_cnt <= 8'd0;
    else if (!freeze)
      leak_cnt <= leak_now ? 8'd0 : leak_cnt + 8'd1;
  end

endmodule

// File: rtl/lif_core.sv
// Leaky integrate-and-fire neuron core: leak, integrate, fire, refractory.
// Optional LIF_SPIKE_COUNT_EN adds a saturating 16-bit fire counter output.
module lif_core
  import lif_pkg::*;
#(
  parameter int VW            = VW_DEF,
  parameter int LEAK_SHIFT    = LEAK_SHIFT_DEF,
  parameter int REFRACT_STEPS = REFRACT_STEPS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_busy,
  input  logic [7:0]    tau,
  input  logic [7:0]    weight,
  input  logic [7:0]    threshold,
  input  logic          step_en,
  input  logic          spike_in,
  output logic          spike_out,
  output logic          refractory,
  output logic [VW-1:0] membrane
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [15:0]   spike_count
`endif
);

  // Wide enough for REFRACT_STEPS, and at least one bit when it is 0.
  localparam int RW = $clog2(REFRACT_STEPS + 2);
  localparam logic [31:0] V_MAX = 32'((64'd1 << VW) - 64'd1);

  lif_state_e    state, state_nx;
  logic [VW-1:0] v, v_nx, v_leak, v_int;
  logic [RW-1:0] ref_cnt, ref_nx;
  logic          leak_now, hit, fire_now, lt_clear, lt_freeze;

  lif_leak_timer u_leak (
    .clk      (clk),
    .rst      (rst),
    .clear    (lt_clear),
    .freeze   (lt_freeze),
    .tau      (tau),
    .leak_now (leak_now)
  );

  assign v_leak   = leak_now ? v - (v >> LEAK_SHIFT) : v;
  assign v_int    = VW'(sat_add(32'(v_leak), spike_in ? 32'(weight) : 32'd0, V_MAX));
  assign hit      = (threshold != 8'd0) && (v_int >= VW'(threshold));
  assign membrane = v;

  // Next-state, membrane update and leak timer control.
  always_comb begin
    state_nx  = state;
    v_nx      = v;
    ref_nx    = ref_cnt;
    fire_now  = 1'b0;
    lt_clear  = 1'b0;
    lt_freeze = 1'b1;
    if (cfg_busy) begin
      state_nx = IDLE;
      v_nx     = '0;
      ref_nx   = '0;
      lt_clear = 1'b1;
    end else begin
      case (state)
        IDLE:   state_nx = INTEG;
        INTEG: if (step_en) begin
          lt_freeze = 1'b0;
          if (hit) begin
            v_nx     = '0;
            lt_clear = 1'b1;
            fire_now = 1'b1;
            state_nx = FIRE;
          end else begin
            v_nx = v_int;
          end
        end
        // Single-cycle fire; any step_en arriving here is dropped.
        FIRE: begin
          if (REFRACT_STEPS > 0) begin
            state_nx = REFRAC;
            ref_nx   = RW'(REFRACT_STEPS);
          end else begin
            state_nx = INTEG;
          end
        end
        // Steps are consumed without integrating; the last one re-arms INTEG.
        REFRAC: if (step_en) begin
          ref_nx = ref_cnt - 1'b1;
          if (ref_cnt == RW'(1)) state_nx = INTEG;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, membrane and registered output decode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      v          <= '0;
      ref_cnt    <= '0;
      spike_out  <= 1'b0;
      refractory <= 1'b0;
    end else begin
      state      <= state_nx;
      v          <= v_nx;
      ref_cnt    <= ref_nx;
      spike_out  <= (state_nx == FIRE);
      refractory <= (state_nx == REFRAC);
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  // Saturating count of FIRE entries.
  always_ff @(posedge clk) begin
    if (!rst || cfg_busy)
      spike_count <= 16'd0;
    else if (fire_now && spike_count != 16'hFFFF)
      spike_count <= spike_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lif_core.sv
// Self-checking bench for lif_core: directed scenarios then random stimulus,
// all compared against an arithmetic reference model of the neuron.
module tb_lif_core;

  localparam int VW = 10;
  localparam int LS = 3;
  localparam int RS = 4;
  localparam int VMAX = (1 << VW) - 1;

  logic          clk = 1'b0;
  logic          rst, cfg_busy, step_en, spike_in;
  logic [7:0]    tau, weight, threshold;
  logic          spike_out, refractory;
  logic [VW-1:0] membrane;
`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0]   spike_count;
`endif

  lif_core #(.VW(VW), .LEAK_SHIFT(LS), .REFRACT_STEPS(RS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_busy   (cfg_busy),
    .tau        (tau),
    .weight     (weight),
    .threshold  (threshold),
    .step_en    (step_en),
    .spike_in   (spike_in),
    .spike_out  (spike_out),
    .refractory (refractory),
    .membrane   (membrane)
`ifdef LIF_SPIKE_COUNT_EN
    ,
    .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase of the neuron plus plain integer bookkeeping.
  localparam int P_OFF = 0, P_RUN = 1, P_FIRED = 2, P_REST = 3;
  int m_phase = P_OFF;
  int m_v = 0, m_steps_since_leak = 0, m_rest_left = 0, m_fires = 0;

  task automatic model_edge();
    int vi;
    if (!rst) begin
      m_phase = P_OFF; m_v = 0; m_steps_since_leak = 0; m_rest_left = 0; m_fires = 0;
    end else if (cfg_busy) begin
      m_phase = P_OFF; m_v = 0; m_steps_since_leak = 0; m_rest_left = 0; m_fires = 0;
    end else if (m_phase == P_OFF) begin
      m_phase = P_RUN;
    end else if (m_phase == P_RUN) begin
      if (step_en) begin
        vi = m_v;
        if (m_steps_since_leak == int'(tau)) begin
          vi = vi - (vi / (1 << LS));
          m_steps_since_leak = 0;
        end else begin
          m_steps_since_leak = (m_steps_since_leak + 1) % 256;
        end
        if (spike_in) vi = vi + int'(weight);
        if (vi > VMAX) vi = VMAX;
        if (threshold != 0 && vi >= int'(threshold)) begin
          m_v = 0; m_steps_since_leak = 0; m_phase = P_FIRED;
          if (m_fires < 65535) m_fires++;
        end else begin
          m_v = vi;
        end
      end
    end else if (m_phase == P_FIRED) begin
      if (RS > 0) begin m_phase = P_REST; m_rest_left = RS; end
      else m_phase = P_RUN;
    end else begin
      if (step_en) begin
        m_rest_left--;
        if (m_rest_left == 0) m_phase = P_RUN;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: DUT and model advance on the same edge, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("membrane", 32'(membrane), 32'(m_v));
    chk("spike_out", 32'(spike_out), 32'(m_phase == P_FIRED));
    chk("refractory", 32'(refractory), 32'(m_phase == P_REST));
`ifdef LIF_SPIKE_COUNT_EN
    chk("spike_count", 32'(spike_count), 32'(m_fires));
`endif
  endtask

  task automatic step(input logic sp);
    step_en = 1'b1; spike_in = sp;
    tick();
    step_en = 1'b0; spike_in = 1'b0;
  endtask

  task automatic busy_pulse();
    cfg_busy = 1'b1; tick();
    cfg_busy = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b0; cfg_busy = 1'b1; step_en = 1'b1; spike_in = 1'b1;
    tau = 8'd0; weight = 8'd20; threshold = 8'd50;
    #2;
    // Reset dominates busy and step.
    tick(); tick();
    chk("rst_membrane", 32'(membrane), 32'd0);
    chk("rst_spike", 32'(spike_out), 32'd0);
    chk("rst_refr", 32'(refractory), 32'd0);

    // Integrate to fire: 20, 38, then 54 crosses 50.
    rst = 1'b1; cfg_busy = 1'b0; step_en = 1'b0; spike_in = 1'b0;
    tick();
    step(1'b1); chk("int_v1", 32'(membrane), 32'd20); tick();
    step(1'b1); chk("int_v2", 32'(membrane), 32'd38); tick();
    step(1'b1);
    chk("fire_pulse", 32'(spike_out), 32'd1);
    chk("fire_v0", 32'(membrane), 32'd0);
    tick();
    chk("fire_one_cycle", 32'(spike_out), 32'd0);
    chk("refr_enter", 32'(refractory), 32'd1);

    // Four refractory steps are swallowed, fifth integrates from 0.
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("refr_v", 32'(membrane), 32'd0);
      chk("refr_flag", 32'(refractory), 32'(i < 3));
      tick();
    end
    step(1'b1); chk("post_refr_v", 32'(membrane), 32'd20);

    // Fire again, then drop into configuration mid-refractory.
    step(1'b1); step(1'b1); tick();
    chk("refr_again", 32'(refractory), 32'd1);
    cfg_busy = 1'b1; tick();
    chk("busy_v", 32'(membrane), 32'd0);
    chk("busy_refr", 32'(refractory), 32'd0);
    cfg_busy = 1'b0; weight = 8'd33; tick();
    step(1'b1); chk("busy_fresh_v", 32'(membrane), 32'd33);

    // Leak interval tau=2: leak lands on the third step.
    tau = 8'd2; weight = 8'd40; threshold = 8'd255;
    busy_pulse();
    step(1'b1); chk("leak_s1", 32'(membrane), 32'd40);
    step(1'b0); chk("leak_s2", 32'(membrane), 32'd40);
    step(1'b0); chk("leak_s3", 32'(membrane), 32'd35);
    step(1'b0); chk("leak_s4", 32'(membrane), 32'd35);

    // Saturation with firing disabled.
    tau = 8'd0; weight = 8'd255; threshold = 8'd0;
    busy_pulse();
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      chk("sat_nofire", 32'(spike_out), 32'd0);
    end
    chk("sat_v", 32'(membrane), 32'd1023);

    // Random traffic, including mid-run tau/weight/threshold changes.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      cfg_busy  = ($urandom_range(0, 99) < 2);
      step_en   = ($urandom_range(0, 2) == 0);
      spike_in  = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 31) == 0) tau = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 31) == 0) weight = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0)
        threshold = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
